jacobi_sweep_ctrl: RTL

- Sequences the combinational jacobi relaxation datapath.
  - Owns the solution-vector register that feeds the datapath and captures its output every cycle.
  - Counts iterations and stops on convergence or on an iteration cap.
- Sits between a host/loader (start, initial vector, limits) and the jacobi instance (u_state out, u_next in).
- This replaces free-running feedback with a start/done-controlled solve.

---
 rtl/jacobi_sweep_ctrl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/jacobi_sweep_ctrl.sv
// Start/done controller for the combinational Jacobi relaxation datapath.
// Holds the solution vector, commits one sweep per RUN cycle, stops on convergence or cap.
module jacobi_sweep_ctrl #(
    parameter int WIDTH = 8,
    parameter int NU    = 10,
    parameter int ITW   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [WIDTH*NU-1:0] init_u,
    input  logic [ITW-1:0]      max_iters,
    input  logic [WIDTH-1:0]    tol,
    input  logic [WIDTH*NU-1:0] u_next,
    output logic [WIDTH*NU-1:0] u_state,
    output logic                busy,
    output logic                done,
    output logic                converged,
    output logic [ITW-1:0]      iter_count
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [WIDTH*NU-1:0] u_q, u_d;
    logic [ITW-1:0]      iter_q, iter_d;
    logic                conv_q, conv_d;
    logic [ITW-1:0]      max_q, max_d;
    logic [WIDTH-1:0]    tol_q, tol_d;

    logic [WIDTH-1:0]    diff [NU];
    logic [WIDTH-1:0]    delta;
    logic [ITW-1:0]      iterInc;

    // Largest per-element change; the difference is taken in the larger-minus-smaller
    // direction so that 255->0 reads as 255 instead of wrapping to 1.
    always_comb begin
        delta = '0;
        for (int i = 0; i < NU; i++) begin
            if (u_next[i*WIDTH +: WIDTH] >= u_q[i*WIDTH +: WIDTH]) begin
                diff[i] = u_next[i*WIDTH +: WIDTH] - u_q[i*WIDTH +: WIDTH];
            end else begin
                diff[i] = u_q[i*WIDTH +: WIDTH] - u_next[i*WIDTH +: WIDTH];
            end
            if (diff[i] > delta) begin
                delta = diff[i];
            end
        end
    end

    assign iterInc = iter_q + ITW'(1);

    always_comb begin
        state_d = state_q;
        u_d     = u_q;
        iter_d  = iter_q;
        conv_d  = conv_q;
        max_d   = max_q;
        tol_d   = tol_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    u_d     = init_u;
                    iter_d  = '0;
                    conv_d  = 1'b0;
                    max_d   = max_iters;
                    tol_d   = tol;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                state_d = (max_q == '0) ? DONE : RUN;
            end
            RUN: begin
                // Abort discards the current sweep entirely.
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    u_d    = u_next;
                    iter_d = iterInc;
                    if (delta <= tol_q) begin
                        conv_d  = 1'b1;
                        state_d = DONE;
                    end else if (iterInc == max_q) begin
                        conv_d  = 1'b0;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            u_q     <= '0;
            iter_q  <= '0;
            conv_q  <= 1'b0;
            max_q   <= '0;
            tol_q   <= '0;
        end else begin
            state_q <= state_d;
            u_q     <= u_d;
            iter_q  <= iter_d;
            conv_q  <= conv_d;
            max_q   <= max_d;
            tol_q   <= tol_d;
        end
    end

    assign u_state    = u_q;
    assign busy       = (state_q == LOAD) || (state_q == RUN);
    assign done       = (state_q == DONE);
    assign converged  = conv_q;
    assign iter_count = iter_q;

endmodule
